// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared types and constants for the matrix loader and ALU stage
package matrix_pkg;

  localparam int ELE_IDX_W        = 5;
  localparam int NUM_ELEM_DEFAULT = 18;
  localparam int A_BASE           = 0;
  localparam int B_BASE           = 9;

  localparam logic [5:0] SEL_NOP = 6'd0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_HOLD   = 3'd2,
    ST_OPWAIT = 3'd3,
    ST_DONE   = 3'd4
  } loader_state_e;

endpackage

// File: rtl/matrix_elem_loader.sv
// rtl/matrix_elem_loader.sv - streams 18 words into the ALU element slots, then presents the op
// Optional running checksum of accepted words: LOADER_CHECKSUM_EN
module matrix_elem_loader
  import matrix_pkg::*;
#(
  parameter int NUM_ELEM = NUM_ELEM_DEFAULT,
  parameter int HOLD     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  input  logic        op_valid,
  input  logic [5:0]  op_code,
  output logic [4:0]  eleSel,
  output logic [31:0] eleIn,
  output logic [5:0]  sel,
  output logic        busy,
  output logic        done,
  output logic [4:0]  count
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0] checksum
`endif
);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_ACCEPT = ST_ACCEPT;
  localparam logic [2:0] S_HOLD   = ST_HOLD;
  localparam logic [2:0] S_OPWAIT = ST_OPWAIT;
  localparam logic [2:0] S_DONE   = ST_DONE;

  localparam logic [3:0]           HOLD_LOAD = 4'(HOLD - 1);
  localparam logic [ELE_IDX_W-1:0] LAST_CNT  = ELE_IDX_W'(NUM_ELEM);

  logic [2:0]           state_q, state_d;
  logic [ELE_IDX_W-1:0] idx_q, idx_d;
  logic [ELE_IDX_W-1:0] count_q, count_d;
  logic [ELE_IDX_W-1:0] ele_sel_q, ele_sel_d;
  logic [31:0]          ele_in_q, ele_in_d;
  logic [5:0]           sel_q, sel_d;
  logic [3:0]           hold_q, hold_d;
  logic                 done_q, done_d;
  logic                 in_ready_q, in_ready_d;
  logic                 busy_q, busy_d;
  logic                 start_fire;
  logic                 accept;

  assign start_fire = start && (state_q == S_IDLE || state_q == S_DONE);
  assign accept     = in_valid && (state_q == S_ACCEPT);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    count_d   = count_q;
    ele_sel_d = ele_sel_q;
    ele_in_d  = ele_in_q;
    sel_d     = sel_q;
    hold_d    = hold_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_fire) begin
          state_d = S_ACCEPT;
          idx_d   = '0;
          count_d = '0;
          sel_d   = SEL_NOP;
        end
      end
      S_ACCEPT: begin
        if (accept) begin
          ele_in_d  = in_data;
          ele_sel_d = idx_q;
          hold_d    = HOLD_LOAD;
          state_d   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_q == 4'd0) begin
          count_d = count_q + 5'd1;
          // Index saturates on the last slot so it never points past the frame.
          if (count_d == LAST_CNT) begin
            state_d = S_OPWAIT;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = S_ACCEPT;
          end
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end
      S_OPWAIT: begin
        if (op_valid) begin
          sel_d     = op_code;
          ele_sel_d = '0;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        sel_d   = SEL_NOP;
      end
    endcase
    in_ready_d = (state_d == S_ACCEPT);
    busy_d     = (state_d == S_ACCEPT) || (state_d == S_HOLD) || (state_d == S_OPWAIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      count_q    <= '0;
      ele_sel_q  <= '0;
      ele_in_q   <= '0;
      sel_q      <= SEL_NOP;
      hold_q     <= '0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      ele_sel_q  <= ele_sel_d;
      ele_in_q   <= ele_in_d;
      sel_q      <= sel_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;
  assign eleSel   = ele_sel_q;
  assign eleIn    = ele_in_q;
  assign sel      = sel_q;

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (start_fire) begin
      checksum_d = '0;
    end else if (accept) begin
      checksum_d = checksum_q + in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_matrix_elem_loader.sv
// tb/tb_matrix_elem_loader.sv - scoreboard bench for matrix_elem_loader (HOLD=2, NUM_ELEM=18)
module tb_matrix_elem_loader;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } elem_t;

  typedef struct {
    logic [5:0] op;
    logic [4:0] cnt;
  } op_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        op_valid = 1'b0;
  logic [5:0]  op_code = '0;
  logic [4:0]  eleSel;
  logic [31:0] eleIn;
  logic [5:0]  sel;
  logic        busy;
  logic        done;
  logic [4:0]  count;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  elem_t elem_q[$];
  op_t   op_q[$];

  matrix_elem_loader #(.NUM_ELEM(18), .HOLD(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .op_valid (op_valid),
    .op_code  (op_code),
    .eleSel   (eleSel),
    .eleIn    (eleIn),
    .sel      (sel),
    .busy     (busy),
    .done     (done),
    .count    (count)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Element monitor: each accepted word must appear on eleSel/eleIn and stay there for HOLD cycles
  initial forever begin
    elem_t e;
    @(posedge clk);
    if (!reset && in_valid && in_ready) begin
      @(negedge clk);
      if (elem_q.size() == 0) begin
        chk("accept_unexpected", {31'd0, in_ready}, 32'd0);
      end else begin
        e = elem_q.pop_front();
        chk("elem_sel", {27'd0, eleSel}, {27'd0, e.idx});
        chk("elem_data", eleIn, e.data);
        @(negedge clk);
        if (!reset) begin
          chk("hold_sel", {27'd0, eleSel}, {27'd0, e.idx});
          chk("hold_data", eleIn, e.data);
        end
      end
    end
  end

  // Completion monitor
  initial forever begin
    op_t o;
    @(negedge clk);
    if (!reset && done) begin
      if (op_q.size() == 0) begin
        chk("done_unexpected", {31'd0, done}, 32'd0);
      end else begin
        o = op_q.pop_front();
        chk("done_sel", {26'd0, sel}, {26'd0, o.op});
        chk("done_count", {27'd0, count}, {27'd0, o.cnt});
        chk("done_readout_sel", {27'd0, eleSel}, 32'd0);
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic [4:0] idx);
    bit ok;
    elem_t e;
    e.idx = idx;
    e.data = d;
    elem_q.push_back(e);
    in_data = d;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_opwait();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (count == 5'd18 && busy && !in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("opwait_reached", {31'd0, ok}, 32'd1);
  endtask

  task automatic issue_op(input logic [5:0] code);
    op_t o;
    o.op = code;
    o.cnt = 5'd18;
    op_q.push_back(o);
    op_valid = 1'b1;
    op_code = code;
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    chk("done_single_cycle", {31'd0, done}, 32'd0);
    chk("sel_held", {26'd0, sel}, {26'd0, code});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_eleSel", {27'd0, eleSel}, 32'd0);
    chk("rst_eleIn", eleIn, 32'd0);
    chk("rst_sel", {26'd0, sel}, 32'd0);
    chk("rst_flags", {28'd0, in_ready, busy, done, 1'b0}, 32'd0);
    chk("rst_count", {27'd0, count}, 32'd0);
`ifdef LOADER_CHECKSUM_EN
    chk("rst_checksum", checksum, 32'd0);
`endif
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", {31'd0, in_ready}, 32'd0);

    // Partial frame aborted by asynchronous reset in the middle of word 5's hold
    pulse_start();
    for (int i = 0; i < 5; i++) send(32'hA0 + i, 5'(i));
    in_valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_eleSel", {27'd0, eleSel}, 32'd0);
    chk("async_rst_eleIn", eleIn, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_count", {27'd0, count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Full load, upstream always valid, timing of OPWAIT entry
    pulse_start();
    t0 = cyc;
    chk("f1_ready_after_start", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 18; i++) send(32'(i + 1), 5'(i));
    in_valid = 1'b0;
    wait_opwait();
    chk("f1_opwait_cycles", 32'(cyc - t0), 32'd54);
    chk("f1_opwait_sel", {26'd0, sel}, 32'd0);
    issue_op(6'd3);

    // Restart from DONE, backpressure after word 9, op_valid in ACCEPT, start in HOLD
    pulse_start();
    chk("restart_sel", {26'd0, sel}, 32'd0);
    chk("restart_count", {27'd0, count}, 32'd0);
    chk("restart_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 9; i++) send(32'h100 + i, 5'(i));
    in_valid = 1'b0;
    op_valid = 1'b1;
    op_code = 6'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_eleSel", {27'd0, eleSel}, 32'd8);
      chk("bp_sel", {26'd0, sel}, 32'd0);
    end
    op_valid = 1'b0;
    send(32'h109, 5'd9);
    pulse_start();
    chk("start_in_hold_count", {27'd0, count}, 32'd9);
    chk("start_in_hold_busy", {31'd0, busy}, 32'd1);
    for (int i = 10; i < 18; i++) send(32'h100 + i, 5'(i));
    in_valid = 1'b0;
    wait_opwait();
    issue_op(6'h2A);

`ifdef LOADER_CHECKSUM_EN
    pulse_start();
    chk("cks_cleared", checksum, 32'd0);
    send(32'hFFFF_FFFF, 5'd0);
    send(32'h0000_0002, 5'd1);
    for (int i = 2; i < 18; i++) send(32'd0, 5'(i));
    in_valid = 1'b0;
    wait_opwait();
    chk("cks_wrap", checksum, 32'h0000_0001);
    issue_op(6'd1);
    chk("cks_stable_done", checksum, 32'h0000_0001);
`endif

    repeat (4) @(negedge clk);
    chk("elem_q_drained", elem_q.size(), 32'd0);
    chk("op_q_drained", op_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_elem_loader.md
# matrix_elem_loader

Upstream sequencer for the 3×3 matrix ALU.
- Accepts a valid/ready stream of 32-bit words and writes them in order into the 18 element slots: matrix A at indices 0–8, matrix B at 9–17.
- Drives `eleSel`/`eleIn`, holding each element stable for a fixed number of cycles.
- Once both matrices are loaded, presents the requested operation on `sel` and signals completion.
- Sits between the board input logic and the ALU calculation stage, whose `eleSel`, `sel` and `eleIn` inputs it drives directly.

## Interface
Parameters:
- `NUM_ELEM`, 18, number of element slots loaded per frame (two 3×3 matrices).
- `HOLD`, 2, cycles each element is held on `eleSel`/`eleIn`; legal range 1–15.

Ports:
- `clk`, input, 1, single clock; all logic is on its rising edge.
- `reset`, input, 1, asynchronous, active-high; returns the block to IDLE immediately.
- `start`, input, 1, one-cycle pulse that begins a new frame; ignored unless in IDLE or DONE.
- `in_valid`, input, 1, upstream word valid.
- `in_data`, input, 32, upstream word.
- `in_ready`, output, 1, block accepts a word this cycle.
- `op_valid`, input, 1, operation code valid.
- `op_code`, input, 6, operation to present on `sel`.
- `eleSel`, output, 5, element index to the ALU.
- `eleIn`, output, 32, element value to the ALU.
- `sel`, output, 6, operation select to the ALU; 6'd0 = NOP.
- `busy`, output, 1, high in ACCEPT, HOLD and OPWAIT.
- `done`, output, 1, one-cycle pulse on entry to DONE.
- `count`, output, 5, number of words accepted in the current frame.
- `checksum`, output, 32, present only with `LOADER_CHECKSUM_EN`.

## Operation
States: IDLE, ACCEPT, HOLD, OPWAIT, DONE.
- **IDLE**
  - `in_ready`=0.
  - On `start`: go to ACCEPT; clear `count`, index and checksum.
- **ACCEPT**
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: register `in_data`→`eleIn` and index→`eleSel`, load the hold counter with HOLD−1, then go to HOLD.
- **HOLD**
  - `in_ready`=0; `eleSel`/`eleIn` are stable.
  - When the hold counter reaches 0: increment index and `count`.
  - If `count` is then NUM_ELEM, go to OPWAIT; otherwise go to ACCEPT.
- **OPWAIT**
  - `sel`=0.
  - On `op_valid`: register `op_code`→`sel` and go to DONE.
- **DONE**
  - `done` pulses for the first cycle only.
  - `sel` holds the operation; `eleSel` is driven to 0 for result readout.
  - On `start`: begin a new frame exactly as from IDLE. `sel` returns to 0 in the cycle after `start`.
- `sel` is 0 in every state except DONE.
- `start` while `busy` is ignored and has no effect on the frame.
- `op_valid` outside OPWAIT is ignored and is not buffered.
- `in_valid` outside ACCEPT is ignored; upstream must hold the word until it sees `in_ready`.
- Index width is 5 bits. No wrap-around within a frame: the index never exceeds NUM_ELEM−1.
- Reset values of all outputs:
  - `eleSel`=0, `eleIn`=0, `sel`=0.
  - `in_ready`=0, `busy`=0, `done`=0, `count`=0.
  - `checksum`=0.
  - State = IDLE.
- Reset mid-frame discards the partial load. The ALU contents are not touched by the reset beyond `sel` returning to NOP.

## Timing
- Word accepted at edge N: `eleSel`/`eleIn` are updated after edge N and held for HOLD cycles.
- `in_ready` reasserts HOLD+1 cycles after the accept edge. Maximum throughput is one word per HOLD+1 cycles.
- A full load with upstream always valid takes NUM_ELEM×(HOLD+1) cycles from the first ACCEPT cycle to OPWAIT.
- `op_valid` sampled at edge M: `sel` is updated after edge M, and `done` is high for the cycle following edge M.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- **`LOADER_CHECKSUM_EN` defined:**
  - `checksum` port exists.
  - On each accept, `checksum` += `in_data`, modulo 2^32.
  - Cleared on `start`; stable from OPWAIT until the next `start`.
- **Not defined:** the `checksum` port and its adder are absent. All other behaviour is identical.

## Structure
- Shared package `matrix_pkg` holds:
  - the state enum;
  - `NUM_ELEM_DEFAULT`=18, `A_BASE`=0, `B_BASE`=9;
  - `SEL_NOP`=6'd0;
  - the element index width of 5.
- The same package is imported by the ALU stage.
- Single module; no sub-module is warranted. The hold counter is a 4-bit down-counter inline.

## Test plan
- **Reset:** assert `reset` asynchronously mid-HOLD at word 5 → all outputs 0 and state IDLE within the same cycle. `start` then reloads from index 0.
- **Full load, HOLD=2:** feed words 1..18 with `in_valid` always high → `eleSel` steps 0..17, each value held 2 cycles. OPWAIT is reached 54 cycles after the first ACCEPT cycle, with `count`=18.
- **Backpressure:** drop `in_valid` for 5 cycles after word 9 → `eleSel` stays at 8. Word 10 lands at index 9, with no skipped or duplicated slot.
- **Operation:**
  - Pulse `op_valid` with `op_code`=6'd3 in OPWAIT → `sel`=3 on the next cycle and a single-cycle `done`.
  - `op_valid` during ACCEPT → `sel` stays 0.
- **Restart:** `start` in DONE → `sel`=0, `count`=0, `in_ready`=1 next cycle. `start` during HOLD → ignored.
- **Checksum (macro on):** words 0xFFFFFFFF, 0x2, then 0x0 ×16 → `checksum`=0x00000001, showing modulo wrap.
